// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types: datapath widths and the {val, addr, tag} entry
// carried by the common data bus, reused by ROB and reservation stations.
// No ports; imported by every file in this slice.
package cdb_arbiter_pkg;

    localparam int REG_VAL_WIDTH          = 32;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;
    localparam int ROB_SIZE_WIDTH         = 5;

    typedef struct packed {
        logic [REG_VAL_WIDTH-1:0]          val;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] addr;
        logic [ROB_SIZE_WIDTH-1:0]         tag;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of functional-unit result inputs and the broadcast CDB outputs.
// master = result producers (drive src_*, observe cdb_*); slave = the arbiter.
// src_ready is the per-source "buffer not full" backpressure signal.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) ();

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]                             src_valid;
    logic [NUM_SRC-1:0][REG_VAL_WIDTH-1:0]          src_val;
    logic [NUM_SRC-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] src_addr;
    logic [NUM_SRC-1:0][ROB_SIZE_WIDTH-1:0]         src_tag;
    logic [NUM_SRC-1:0]                             src_ready;

    logic                              cdb_valid;
    logic [REG_VAL_WIDTH-1:0]          cdb_val;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_addr;
    logic [ROB_SIZE_WIDTH-1:0]         cdb_tag;
    logic [SRC_W-1:0]                  cdb_src;
    logic                              overflow_err;

    modport master (
        output src_valid, src_val, src_addr, src_tag,
        input  src_ready, cdb_valid, cdb_val, cdb_addr, cdb_tag, cdb_src, overflow_err
    );

    modport slave (
        input  src_valid, src_val, src_addr, src_tag,
        output src_ready, cdb_valid, cdb_val, cdb_addr, cdb_tag, cdb_src, overflow_err
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO of cdb_entry_t with synchronous flush.
// Latency: a push is visible at head/empty the cycle after it is accepted.
// Backpressure: pushes while full are ignored; full reflects stored occupancy only.
// Ports: clk, reset (async, active-high), flush, push/push_dat, pop, full, empty, head.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t push_dat,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    cdb_entry_t    mem_q [DEPTH];
    cdb_entry_t    mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // Flush dominates: neither a push nor a pop may land in a cycle being cleared.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_SRC units and broadcasts one per cycle, round-robin.
// Latency: 2 cycles from src_valid sampled to cdb_valid (buffer write, then registered grant).
// Backpressure: src_ready[i] = buffer i not full; pushes to a full buffer are dropped and flag overflow_err.
// Ports: clk, reset (async, active-high), flush (sync clear), bus (slave side of cdb_arbiter_if).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [SRC_W:0] NUM_SRC_W = NUM_SRC[SRC_W:0];

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;
    cdb_entry_t         push_dat [NUM_SRC];
    cdb_entry_t         head     [NUM_SRC];

    logic               grant;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W:0]     idx;
    logic [SRC_W:0]     nxt;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    cdb_entry_t         cdb_dat_q, cdb_dat_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;
    logic               overflow_q, overflow_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_dat[i] = '{val:  bus.src_val[i],
                               addr: bus.src_addr[i],
                               tag:  bus.src_tag[i]};

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .push     (bus.src_valid[i]),
            .push_dat (push_dat[i]),
            .pop      (pop[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .head     (head[i])
        );
    end

    // Round-robin pick: scan offsets from the far end back toward rr_ptr so the
    // last hit written is the nearest non-empty source at or after rr_ptr.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + k[SRC_W:0];
            if (idx >= NUM_SRC_W) begin
                idx = idx - NUM_SRC_W;
            end
            if (!empty[idx[SRC_W-1:0]]) begin
                grant  = 1'b1;
                winner = idx[SRC_W-1:0];
            end
        end
        // A flush cycle empties everything, so nothing may be granted from it.
        if (flush) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        pop = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
    end

    always_comb begin
        nxt = {1'b0, winner} + 1'b1;
        if (nxt == NUM_SRC_W) begin
            nxt = '0;
        end
        rr_ptr_d    = grant ? nxt[SRC_W-1:0] : rr_ptr_q;
        cdb_valid_d = grant;
        // Payload holds its last broadcast value on idle cycles.
        cdb_dat_d   = grant ? head[winner] : cdb_dat_q;
        cdb_src_d   = grant ? winner : cdb_src_q;
        overflow_d  = overflow_q | (|(bus.src_valid & full));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_dat_q   <= '0;
            cdb_src_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_dat_q   <= cdb_dat_d;
            cdb_src_q   <= cdb_src_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.src_ready    = ~full;
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_val      = cdb_dat_q.val;
    assign bus.cdb_addr     = cdb_dat_q.addr;
    assign bus.cdb_tag      = cdb_dat_q.tag;
    assign bus.cdb_src      = cdb_src_q;
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_SRC=4, FIFO_DEPTH=2).
// Cycle c means the interval after the c-th rising edge of a scenario; outputs
// are sampled 1 time unit after the edge, inputs driven right after sampling.
module tb_cdb_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    cdb_arbiter_if #(.NUM_SRC(4)) bus ();

    cdb_arbiter #(
        .NUM_SRC    (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.src_valid = '0;
        bus.src_val   = '0;
        bus.src_addr  = '0;
        bus.src_tag   = '0;
        flush         = 1'b0;
    endtask

    task automatic push(input int s, input logic [31:0] v, input logic [5:0] a, input logic [4:0] t);
        bus.src_valid[s] = 1'b1;
        bus.src_val[s]   = v;
        bus.src_addr[s]  = a;
        bus.src_tag[s]   = t;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
        n_tests++; if (bus.cdb_val !== 32'h0 || bus.cdb_addr !== 6'd0 || bus.cdb_tag !== 5'd0) begin
            n_fail++; $display("FAIL reset_payload: got val=%h addr=%0d tag=%0d want 0/0/0", bus.cdb_val, bus.cdb_addr, bus.cdb_tag); end
        n_tests++; if (bus.cdb_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus.cdb_src); end
        n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); end
        n_tests++; if (bus.src_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b want 1111", bus.src_ready); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_push();
        do_reset();
        push(2, 32'h1234, 6'd5, 5'd3);
        step();
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid: got %b want 0", bus.cdb_valid); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_val !== 32'h1234 || bus.cdb_addr !== 6'd5 ||
                       bus.cdb_tag !== 5'd3 || bus.cdb_src !== 2'd2) begin
            n_fail++; $display("FAIL single_c2: got v=%b val=%h addr=%0d tag=%0d src=%0d want 1/1234/5/3/2",
                               bus.cdb_valid, bus.cdb_val, bus.cdb_addr, bus.cdb_tag, bus.cdb_src); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL single_c3_valid: got %b want 0", bus.cdb_valid); end
        n_tests++; if (bus.cdb_val !== 32'h1234 || bus.cdb_src !== 2'd2) begin
            n_fail++; $display("FAIL single_c3_hold: got val=%h src=%0d want 1234/2", bus.cdb_val, bus.cdb_src); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_v;
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 32'h100 + s, 6'(10 + s), 5'(s));
        step();
        clear_inputs();
        step();
        for (int s = 0; s < 4; s++) begin
            exp_v = 32'h100 + s;
            n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(s) || bus.cdb_val !== exp_v || bus.cdb_addr !== 6'(10 + s)) begin
                n_fail++; $display("FAIL rr_order_%0d: got v=%b src=%0d val=%h addr=%0d want 1/%0d/%h/%0d",
                                   s, bus.cdb_valid, bus.cdb_src, bus.cdb_val, bus.cdb_addr, s, exp_v, 10 + s); end
            step();
        end
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        // c0: srcs 1-3 occupy the next three grant slots.
        for (int s = 1; s < 4; s++) push(s, 32'h60 + s, 6'(s), 5'(s));
        step();
        // c1: grant src1; first src0 push.
        clear_inputs();
        n_tests++; if (bus.src_ready[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_c1: got %b want 1", bus.src_ready[0]); end
        push(0, 32'hA0, 6'd20, 5'd20);
        step();
        // c2: src1 broadcast, grant src2; second src0 push.
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1) begin n_fail++; $display("FAIL ovf_bc_c2: got v=%b src=%0d want 1/1", bus.cdb_valid, bus.cdb_src); end
        n_tests++; if (bus.src_ready[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_c2: got %b want 1", bus.src_ready[0]); end
        push(0, 32'hB0, 6'd21, 5'd21);
        step();
        // c3: src0 full; third push must be dropped.
        clear_inputs();
        n_tests++; if (bus.src_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_c3: got %b want 0", bus.src_ready[0]); end
        n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.overflow_err); end
        n_tests++; if (bus.cdb_src !== 2'd2) begin n_fail++; $display("FAIL ovf_bc_c3: got src=%0d want 2", bus.cdb_src); end
        push(0, 32'hC0, 6'd22, 5'd22);
        step();
        clear_inputs();
        n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.overflow_err); end
        n_tests++; if (bus.cdb_src !== 2'd3 || bus.cdb_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_bc_c4: got v=%b src=%0d want 1/3", bus.cdb_valid, bus.cdb_src); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_val !== 32'hA0) begin
            n_fail++; $display("FAIL ovf_bc_c5: got v=%b src=%0d val=%h want 1/0/a0", bus.cdb_valid, bus.cdb_src, bus.cdb_val); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_val !== 32'hB0) begin
            n_fail++; $display("FAIL ovf_bc_c6: got v=%b src=%0d val=%h want 1/0/b0", bus.cdb_valid, bus.cdb_src, bus.cdb_val); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got v=%b val=%h want v=0", bus.cdb_valid, bus.cdb_val); end
        n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_err); end
    endtask

    task automatic test_push_pop_overlap();
        logic [31:0] exp_v;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            clear_inputs();
            if (c >= 2 && c < 12) begin
                exp_v = 32'h200 + 32'(c - 2);
                n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_val !== exp_v || bus.cdb_tag !== 5'(c - 2)) begin
                    n_fail++; $display("FAIL overlap_bc_c%0d: got v=%b src=%0d val=%h tag=%0d want 1/1/%h/%0d",
                                       c, bus.cdb_valid, bus.cdb_src, bus.cdb_val, bus.cdb_tag, exp_v, c - 2); end
            end else begin
                n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL overlap_idle_c%0d: got %b want 0", c, bus.cdb_valid); end
            end
            n_tests++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL overlap_ready_c%0d: got %b want 1", c, bus.src_ready[1]); end
            if (c < 10) push(1, 32'h200 + 32'(c), 6'(c), 5'(c));
            step();
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 32'h300 + s, 6'(s), 5'(s));
        step();
        clear_inputs();
        push(0, 32'h310, 6'd30, 5'd30);
        push(1, 32'h311, 6'd31, 5'd31);
        step();
        // c2: five entries buffered; earlier grant of src0 is on the bus.
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_val !== 32'h300 || bus.cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL flush_pre: got v=%b val=%h src=%0d want 1/300/0", bus.cdb_valid, bus.cdb_val, bus.cdb_src); end
        n_tests++; if (bus.src_ready !== 4'b1101) begin n_fail++; $display("FAIL flush_pre_ready: got %b want 1101", bus.src_ready); end
        flush = 1'b1;
        push(2, 32'h3FF, 6'd63, 5'd31);
        step();
        clear_inputs();
        n_tests++; if (bus.cdb_val !== 32'h300) begin n_fail++; $display("FAIL flush_hold: got val=%h want 300", bus.cdb_val); end
        for (int c = 3; c < 9; c++) begin
            n_tests++; if (bus.cdb_valid !== 1'b0 || bus.src_ready !== 4'hF) begin
                n_fail++; $display("FAIL flush_c%0d: got v=%b val=%h ready=%b want v=0 ready=1111", c, bus.cdb_valid, bus.cdb_val, bus.src_ready); end
            step();
        end
        // rr_ptr stayed at 1, so src2 is served before src0.
        push(0, 32'h350, 6'd1, 5'd1);
        push(2, 32'h352, 6'd2, 5'd2);
        step();
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post_c10: got %b want 0", bus.cdb_valid); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2 || bus.cdb_val !== 32'h352) begin
            n_fail++; $display("FAIL flush_rr_first: got v=%b src=%0d val=%h want 1/2/352", bus.cdb_valid, bus.cdb_src, bus.cdb_val); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0 || bus.cdb_val !== 32'h350) begin
            n_fail++; $display("FAIL flush_rr_second: got v=%b src=%0d val=%h want 1/0/350", bus.cdb_valid, bus.cdb_src, bus.cdb_val); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_end: got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int s = 0; s < 4; s++) push(s, 32'h500 + s, 6'(s), 5'(s));
        step();
        clear_inputs();
        for (int s = 0; s < 4; s++) push(s, 32'h510 + s, 6'(s), 5'(s));
        step();
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_val !== 32'h500) begin
            n_fail++; $display("FAIL mid_pre: got v=%b val=%h want 1/500", bus.cdb_valid, bus.cdb_val); end
        #3 reset = 1'b1;
        #1;
        n_tests++; if (bus.cdb_valid !== 1'b0 || bus.cdb_val !== 32'h0 || bus.cdb_addr !== 6'd0 ||
                       bus.cdb_tag !== 5'd0 || bus.cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL mid_async: got v=%b val=%h addr=%0d tag=%0d src=%0d want all 0",
                               bus.cdb_valid, bus.cdb_val, bus.cdb_addr, bus.cdb_tag, bus.cdb_src); end
        n_tests++; if (bus.src_ready !== 4'hF || bus.overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_ready: got ready=%b ovf=%b want 1111/0", bus.src_ready, bus.overflow_err); end
        #2 reset = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_%0d: got v=%b val=%h want 0", c, bus.cdb_valid, bus.cdb_val); end
            step();
        end
        push(3, 32'h4AA, 6'd9, 5'd7);
        step();
        clear_inputs();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_new_c1: got %b want 0", bus.cdb_valid); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd3 || bus.cdb_val !== 32'h4AA ||
                       bus.cdb_addr !== 6'd9 || bus.cdb_tag !== 5'd7) begin
            n_fail++; $display("FAIL mid_new_c2: got v=%b src=%0d val=%h addr=%0d tag=%0d want 1/3/4aa/9/7",
                               bus.cdb_valid, bus.cdb_src, bus.cdb_val, bus.cdb_addr, bus.cdb_tag); end
        step();
        n_tests++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_new_c3: got %b want 0", bus.cdb_valid); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_overflow();
        test_push_pop_overlap();
        test_flush();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of functional-unit result sources (ALUs, load unit, ...).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: per-source result buffer entries, power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all buffered results (misprediction recovery).
REQ-006 SHALL have port src_valid  input  NUM_SRC  per-source result-valid strobe (e.g. alu_valid).
REQ-007 SHALL have port src_val  input  NUM_SRC x REG_VAL_WIDTH  per-source result value.
REQ-008 SHALL have port src_addr  input  NUM_SRC x PHYSICAL_REG_NUM_WIDTH  per-source destination physical register.
REQ-009 SHALL have port src_tag  input  NUM_SRC x ROB_SIZE_WIDTH  per-source ROB tag.
REQ-010 SHALL have port src_ready  output  NUM_SRC  per-source "buffer not full".
REQ-011 SHALL have port cdb_valid  output  1  broadcast valid.
REQ-012 SHALL have port cdb_val  output  REG_VAL_WIDTH  broadcast value.
REQ-013 SHALL have port cdb_addr  output  PHYSICAL_REG_NUM_WIDTH  broadcast physical register.
REQ-014 SHALL have port cdb_tag  output  ROB_SIZE_WIDTH  broadcast ROB tag.
REQ-015 SHALL have port cdb_src  output  clog2(NUM_SRC)  index of the winning source.
REQ-016 SHALL have port overflow_err  output  1  sticky flag: a push arrived while its buffer was full.

Function
REQ-017 SHALL give each source its own FIFO of FIFO_DEPTH entries {val, addr, tag}.
REQ-018 SHALL push on a posedge where src_valid[i]=1 and the FIFO is not full.
REQ-019 SHALL make src_ready[i] a combinational function of FIFO i occupancy only (not full); a same-cycle pop SHALL NOT raise it.
REQ-020 SHALL drop a push to a full FIFO, leave the FIFO unchanged and set overflow_err, which holds until reset.
REQ-021 SHALL, each cycle, select as winner the first non-empty FIFO at or after rr_ptr in ascending index with wrap-around, pop its head and register it onto the cdb_* outputs at the next posedge.
REQ-022 SHALL advance rr_ptr to (winner+1) mod NUM_SRC only on a grant; with no grant rr_ptr holds.
REQ-023 SHALL give a minimum latency of 2 cycles: src_valid sampled at the end of cycle t gives cdb_valid=1 in cycle t+2.
REQ-024 SHALL broadcast at most one result per cycle, so sustained throughput is 1 result per cycle.
REQ-025 SHALL drive cdb_valid=0 in a cycle following no grant, and cdb_val/addr/tag/src SHALL then hold their last values.
REQ-026 SHALL allow simultaneous push and pop on one FIFO in the same cycle, leaving occupancy unchanged and preserving order.
REQ-027 SHALL, on flush=1, empty all FIFOs, make no grant, drive cdb_valid=0 next cycle, drop concurrent pushes (flush wins) and leave rr_ptr unchanged.
REQ-028 SHALL deliver per-source results in arrival order with no loss and no duplication.

Reset
REQ-029 SHALL, on reset assertion at any time, immediately empty all FIFOs and set rr_ptr=0, cdb_valid=0, cdb_val=0, cdb_addr=0, cdb_tag=0, cdb_src=0 and overflow_err=0, with src_ready all ones.
REQ-030 SHALL discard any in-flight or buffered result on reset mid-operation, with no broadcast after reset release until a new push.

Structure
REQ-031 SHALL take REG_VAL_WIDTH, PHYSICAL_REG_NUM_WIDTH and ROB_SIZE_WIDTH from the shared defines, and SHALL define the cdb_entry_t struct {val, addr, tag} in the shared package for reuse by ROB and reservation stations.
REQ-032 SHALL implement the per-source buffer as sub-module cdb_src_fifo (push, pop, flush, full, empty, head), instantiated NUM_SRC times; the round-robin pick SHALL stay in cdb_arbiter.

Verification
REQ-033 SHALL cover a single push: src 2 pushes val=0x1234, addr=5, tag=3 at cycle 0 -> cdb_valid=1 in cycle 2 with those values and cdb_src=2, and cdb_valid=0 in cycle 3.
REQ-034 SHALL cover round-robin fairness: all 4 sources push together once, rr_ptr=0 -> broadcasts in src order 0,1,2,3 in consecutive cycles 2..5.
REQ-035 SHALL cover full FIFO and overflow: src 0 pushes 3 times back-to-back with no grants possible (srcs 1-3 kept busy first) -> src_ready[0]=0 after 2 pushes, the third is dropped and overflow_err=1 sticky.
REQ-036 SHALL cover push/pop overlap: src 1 pushes every cycle for 10 cycles with no other sources active -> 10 broadcasts in order, src_ready[1] never 0.
REQ-037 SHALL cover flush: FIFOs hold 5 entries, flush=1 in cycle k together with a push -> cdb_valid=0 in cycle k+1 onward, all src_ready=1, and no old entry ever broadcast.
REQ-038 SHALL cover reset mid-burst: reset asserted asynchronously mid-cycle during traffic -> all outputs at reset values immediately, and the first broadcast after release comes from a new push 2 cycles later.
